// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel coordinates, syncs, blanking and
// line/frame strobes, all advanced by a registered pixel-enable strobe in one clock domain.
module video_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CLK_DIV   = 4,
  parameter int CW        = 10,
  parameter int FC_W      = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic [CW-1:0]   x,
  output logic [CW-1:0]   y,
  output logic            hsync,
  output logic            vsync,
  output logic            video_on,
  output logic            pix_en,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CW-1:0]    H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]    V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]    H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0]    V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0]    HS_FIRST = CW'(H_VISIBLE + H_FP);
  localparam logic [CW-1:0]    HS_LAST  = CW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0]    VS_FIRST = CW'(V_VISIBLE + V_FP);
  localparam logic [CW-1:0]    VS_LAST  = CW'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic             HS_ACT   = (HSYNC_POL != 0);
  localparam logic             VS_ACT   = (VSYNC_POL != 0);

  if (H_VISIBLE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_VISIBLE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      CLK_DIV < 1 || H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_params
    $error("video_timing_gen: invalid timing parameters");
  end

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic [CW-1:0]    x_nxt;
  logic [CW-1:0]    y_nxt;
  logic             advance;
  logic             at_origin;
  logic             hsync_nxt;
  logic             vsync_nxt;
  logic             video_on_nxt;

  // Next position: park overrides everything, otherwise step only on a pixel strobe.
  always_comb begin
    div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;
    advance = run && pix_en;
    x_nxt   = x;
    y_nxt   = y;
    if (!run) begin
      x_nxt = H_LAST;
      y_nxt = V_LAST;
    end else if (pix_en) begin
      if (x == H_LAST) begin
        x_nxt = '0;
        y_nxt = (y == V_LAST) ? '0 : y + 1'b1;
      end else begin
        x_nxt = x + 1'b1;
      end
    end
  end

  // Decode from the next position so the registered syncs line up with registered x/y.
  always_comb begin
    hsync_nxt    = ((x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST)) ? HS_ACT : ~HS_ACT;
    vsync_nxt    = ((y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST)) ? VS_ACT : ~VS_ACT;
    video_on_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
    at_origin    = (x_nxt == '0) && (y_nxt == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div         <= '0;
      pix_en      <= 1'b0;
      x           <= H_LAST;
      y           <= V_LAST;
      hsync       <= ~HS_ACT;
      vsync       <= ~VS_ACT;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      div         <= div_nxt;
      pix_en      <= (div_nxt == DIV_LAST);
      x           <= x_nxt;
      y           <= y_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      video_on    <= video_on_nxt;
      line_start  <= advance && (x_nxt == '0);
      frame_start <= advance && at_origin;
      if (advance && at_origin) begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator. Successor to the fixed 640x480 timing block.
- Produces pixel coordinates, sync pulses with configurable polarity, a blanking flag, and line/frame strobes, all from a single clock domain.
- A pixel-enable strobe replaces the divided-down derived clock. It sits between the system clock and the game/draw logic and the HDMI/VGA output stage.
- Adds a run/park control and a frame counter for game-logic frame pacing.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, active level of hsync (0 = active-low)
VSYNC_POL, 0, active level of vsync
CLK_DIV, 4, clk cycles per pixel (>=1)
CW, 10, coordinate width; H_TOTAL and V_TOTAL must be <= 2^CW
FC_W, 16, frame counter width

Ports:
clk, input, 1, system clock
reset, input, 1, asynchronous, active-high reset
run, input, 1, 1 = generate timing; 0 = park at end-of-frame
x, output, CW, current horizontal position
y, output, CW, current vertical position
hsync, output, 1, horizontal sync, polarity HSYNC_POL
vsync, output, 1, vertical sync, polarity VSYNC_POL
video_on, output, 1, current (x,y) is in the visible area
pix_en, output, 1, one-clk strobe per pixel period
line_start, output, 1, one-clk pulse when x becomes 0
frame_start, output, 1, one-clk pulse when (x,y) becomes (0,0)
frame_count, output, FC_W, completed-frame counter, wraps

Behaviour:
- Totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP and V_TOTAL likewise.
- Per-line region order is visible, front porch, sync, back porch. The same order applies per frame.
- hsync is active for x in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1]. vsync uses the same rule on y.
- video_on = (x < H_VISIBLE) && (y < V_VISIBLE).
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en is registered and high for exactly one clk when div == CLK_DIV-1.
  - With CLK_DIV=1, pix_en is high every clk after the first post-reset edge.
- Advance: on a clk edge with pix_en=1 and run=1:
  - x increments.
  - When x == H_TOTAL-1, x goes to 0 and y increments.
  - When y == V_TOTAL-1 at that point, y goes to 0.
- Output alignment:
  - All outputs are registered and change on the same clk edge as x/y.
  - hsync, vsync and video_on always describe the x/y currently presented. There is zero skew between them.
- Strobes:
  - line_start is high for one clk after the edge where x became 0.
  - frame_start is high for one clk after the edge where (x,y) became (0,0). line_start is also high in that clk.
  - frame_count increments by 1 (mod 2^FC_W) on the same edge that raises frame_start.
- Park position is (H_TOTAL-1, V_TOTAL-1): blanking, syncs inactive. The first advance therefore lands on (0,0) and fires frame_start.
- Reset values:
  - x = H_TOTAL-1, y = V_TOTAL-1.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
  - video_on = 0, pix_en = 0, line_start = 0, frame_start = 0, frame_count = 0, div = 0.
- run = 0:
  - Takes effect at the next clk edge, including mid-line or mid-frame.
  - x/y are forced to the park position and video_on, hsync and vsync take their park values.
  - line_start and frame_start stay 0. frame_count holds.
  - div and pix_en keep running.
- run rising: the next pix_en edge advances to (0,0) with frame_start=1.
- Reset mid-frame: immediate return to reset values; run still gates restart.
- Elaboration fails if any porch, sync or visible parameter is 0, CLK_DIV < 1, or a total exceeds 2^CW.

Test Plan:
- Reset, then release with run=1, CLK_DIV=4 -> pix_en high on every 4th clk. First advance gives x=0, y=0, frame_start=1, line_start=1, frame_count=1, video_on=1.
- Defaults, one full line -> hsync=0 exactly for x=656..751 (96 pixels). video_on=0 for x>=640. x wraps 799->0 with line_start, and y increments.
- Small config (H 4/1/2/1, V 3/1/1/1, CLK_DIV=1, HSYNC_POL=1) -> H_TOTAL=8, V_TOTAL=6. vsync active only at y=4. frame_start every 48 clks. frame_count increments once per frame.
- FC_W=2, run 5 frames -> frame_count sequence 1,2,3,0,1.
- Drop run at x=300, y=100 -> next clk x=799, y=524, video_on=0, syncs inactive, no strobes. Re-raise run -> next pix_en gives (0,0) and frame_start.
- Assert reset at x=500, y=250 -> outputs at reset values asynchronously. After release, first advance gives (0,0) and frame_count=1.
